pc_stack_unit: RTL and testbench

- Consumes the jump/j_mode/call/return strobes from the control unit.
- Owns the program counter (PC) and a hardware return-address stack.
- Produces the instruction fetch address and stack status for the FRANK5000 datapath.
- Sits between the control unit and instruction memory, closing the control-flow loop.

---
 rtl/pc_stack_unit_if.sv | 39 +++
 rtl/pc_stack_unit.sv | 121 ++++++++++++
 tb/tb_pc_stack_unit.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_stack_unit_if.sv
// Control-flow bus between the control unit and pc_stack_unit.
// Latency: none; the interface only carries wires.
// Backpressure: none; the control unit stalls the unit through en.
//
// Ports/signals:
//   control -> unit : en, jump, j_mode[1:0], call, ret (return strobe), target, clr_err
//   unit -> control : pc, stack_lvl, stack_full, stack_empty, stk_ovf, stk_unf, taken
// The return strobe is named ret because return is a reserved word.
interface pc_stack_unit_if #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned STACK_DEPTH = 8
);
    logic                           en;
    logic                           jump;
    logic [1:0]                     j_mode;
    logic                           call;
    logic                           ret;
    logic [ADDR_W-1:0]              target;
    logic                           clr_err;
    logic [ADDR_W-1:0]              pc;
    logic [$clog2(STACK_DEPTH):0]   stack_lvl;
    logic                           stack_full;
    logic                           stack_empty;
    logic                           stk_ovf;
    logic                           stk_unf;
    logic                           taken;

    // Control unit side
    modport master (
        output en, jump, j_mode, call, ret, target, clr_err,
        input  pc, stack_lvl, stack_full, stack_empty, stk_ovf, stk_unf, taken
    );

    // Program-counter / stack unit side
    modport slave (
        input  en, jump, j_mode, call, ret, target, clr_err,
        output pc, stack_lvl, stack_full, stack_empty, stk_ovf, stk_unf, taken
    );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter plus hardware return-address stack for the FRANK5000 fetch path.
// Latency: one cycle from strobe to new pc / stack level / flags; status outputs are registered or derived from lvl.
// Backpressure: none; en=0 freezes every register (pc, stack, flags, taken).
//
// Ports: clk, rst_n (async active-low), bus (pc_stack_unit_if.slave: en, jump, j_mode,
//        call, ret, target, clr_err in; pc, stack_lvl, stack_full, stack_empty,
//        stk_ovf, stk_unf, taken out).
// Optional feature macro: PC_STACK_TRAP_EN -- a call overflow or return underflow
//        redirects the next pc to TRAP_PC and forces taken.
module pc_stack_unit #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned RESET_PC    = 0,
    parameter int unsigned TRAP_PC     = 1023
) (
    input logic            clk,
    input logic            rst_n,
    pc_stack_unit_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] RST_ADDR  = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] TRAP_ADDR = ADDR_W'(TRAP_PC);
    localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, stk_top;
    logic [LVL_W-1:0]  lvl_q, lvl_d, lvl_dec;
    logic              ovf_q, ovf_d, unf_q, unf_d, taken_q, taken_d;
    logic              full, empty, push_req, pop_req, ovf_ev, unf_ev, push_en;
    logic [ADDR_W-1:0] mem [STACK_DEPTH];

    assign pc_inc  = pc_q + ADDR_W'(1);   // wraps naturally at 2^ADDR_W
    assign lvl_dec = lvl_q - LVL_W'(1);
    assign full    = (lvl_q == LVL_MAX);
    assign empty   = (lvl_q == '0);

    // Top of stack is read straight out of the register file; an empty stack
    // reads as the reset vector so a stray return lands somewhere sane.
    assign stk_top = empty ? RST_ADDR : mem[lvl_dec[PTR_W-1:0]];

    // call and ret together is illegal and touches neither stack nor flags.
    assign push_req = bus.call & ~bus.ret;
    assign pop_req  = bus.ret  & ~bus.call;
    assign ovf_ev   = push_req & full;
    assign unf_ev   = pop_req  & empty;

    always_comb begin
        pc_d    = pc_q;
        lvl_d   = lvl_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        taken_d = taken_q;
        push_en = 1'b0;
        if (bus.en) begin
            unique case (bus.j_mode)
                2'b00:   pc_d = pc_q;
                2'b01:   pc_d = pc_inc;
                2'b10:   pc_d = bus.target;
                default: pc_d = stk_top;
            endcase

            // jump only qualifies the taken pulse; j_mode alone steers pc.
            taken_d = bus.jump & bus.j_mode[1];

            if (push_req && !full) begin
                push_en = 1'b1;
                lvl_d   = lvl_q + LVL_W'(1);
            end else if (pop_req && !empty) begin
                lvl_d   = lvl_dec;
            end

            // A fresh error in the same cycle as clr_err keeps the flag set.
            ovf_d = ovf_ev | (ovf_q & ~bus.clr_err);
            unf_d = unf_ev | (unf_q & ~bus.clr_err);

`ifdef PC_STACK_TRAP_EN
            if (ovf_ev || unf_ev) begin
                pc_d    = TRAP_ADDR;
                taken_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RST_ADDR;
            lvl_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            lvl_q   <= lvl_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            taken_q <= taken_d;
        end
    end

    // Stack storage needs no reset: entries above lvl are never read.
    // The pushed value is pc+1 of the current pc, even when the same edge
    // moves pc to the call target.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[lvl_q[PTR_W-1:0]] <= pc_inc;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.stack_lvl   = lvl_q;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.stk_ovf     = ovf_q;
    assign bus.stk_unf     = unf_q;
    assign bus.taken       = taken_q;

    // Keep the trap vector referenced when the trap feature is compiled out.
    logic unused_trap;
    assign unused_trap = ^TRAP_ADDR;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed scenarios plus a randomized
// run against a queue-based reference model of the pc and return stack.
module tb_pc_stack_unit;
    localparam int AW    = 10;
    localparam int DEPTH = 8;
    localparam int RPC   = 0;
    localparam int TPC   = 1023;
`ifdef PC_STACK_TRAP_EN
    localparam int OVF_PC = TPC;
    localparam int UNF_PC = TPC;
`else
    localparam int OVF_PC = 'h300;
    localparam int UNF_PC = RPC;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pc_stack_unit_if #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) bus ();

    pc_stack_unit #(
        .ADDR_W(AW), .STACK_DEPTH(DEPTH), .RESET_PC(RPC), .TRAP_PC(TPC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_pc;
    int m_stk[$];
    bit m_ovf, m_unf, m_taken;

    function automatic void model_reset();
        m_pc = RPC;
        m_stk.delete();
        m_ovf = 0; m_unf = 0; m_taken = 0;
    endfunction

    function automatic void model_step(bit en, bit jump, bit [1:0] jm, bit cl, bit rt,
                                       int tgt, bit clr);
        int  top, npc;
        bit  push, pop, ovf, unf;
        if (!en) return;
        top  = (m_stk.size() > 0) ? m_stk[$] : RPC;
        push = cl && !rt;
        pop  = rt && !cl;
        ovf  = push && (m_stk.size() == DEPTH);
        unf  = pop && (m_stk.size() == 0);
        case (jm)
            2'd0: npc = m_pc;
            2'd1: npc = (m_pc + 1) % (1 << AW);
            2'd2: npc = tgt;
            default: npc = top;
        endcase
        m_taken = jump && jm[1];
`ifdef PC_STACK_TRAP_EN
        if (ovf || unf) begin
            npc = TPC;
            m_taken = 1;
        end
`endif
        if (push && !ovf) m_stk.push_back((m_pc + 1) % (1 << AW));
        if (pop && !unf) void'(m_stk.pop_back());
        m_ovf = ovf || (m_ovf && !clr);
        m_unf = unf || (m_unf && !clr);
        m_pc  = npc;
    endfunction

    // Apply one cycle of inputs, advance the model, sample 1 ns after the edge.
    task automatic drive(input bit en, input bit jump, input bit [1:0] jm, input bit cl,
                         input bit rt, input int tgt, input bit clr);
        bus.en      = en;
        bus.jump    = jump;
        bus.j_mode  = jm;
        bus.call    = cl;
        bus.ret     = rt;
        bus.target  = AW'(tgt);
        bus.clr_err = clr;
        model_step(en, jump, jm, cl, rt, tgt, clr);
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        checks += 5;
        if (bus.pc !== AW'(RPC)) begin errors++; $display("FAIL reset_pc got=%0h exp=%0h", bus.pc, RPC); end
        if (bus.stack_lvl !== 4'd0) begin errors++; $display("FAIL reset_lvl got=%0d exp=0", bus.stack_lvl); end
        if (bus.stk_ovf !== 1'b0 || bus.stk_unf !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", bus.stk_ovf, bus.stk_unf); end
        if (bus.taken !== 1'b0) begin errors++; $display("FAIL reset_taken got=%b exp=0", bus.taken); end
        if (bus.stack_empty !== 1'b1 || bus.stack_full !== 1'b0) begin errors++; $display("FAIL reset_status got=e%b f%b exp=e1 f0", bus.stack_empty, bus.stack_full); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_increment_wrap();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 2'd1, 0, 0, 0, 0);
            checks++;
            if (bus.pc !== AW'(i + 1) || bus.taken !== 1'b0 || bus.stack_empty !== 1'b1) begin
                errors++;
                $display("FAIL inc_step%0d got pc=%0d taken=%b empty=%b exp pc=%0d taken=0 empty=1", i, bus.pc, bus.taken, bus.stack_empty, i + 1);
            end
        end
        drive(1, 0, 2'd2, 0, 0, 1023, 0);
        drive(1, 0, 2'd1, 0, 0, 0, 0);
        checks++;
        if (bus.pc !== 10'd0 || bus.stk_ovf !== 1'b0 || bus.stk_unf !== 1'b0) begin
            errors++;
            $display("FAIL pc_wrap got pc=%0d flags=%b%b exp pc=0 flags=00", bus.pc, bus.stk_ovf, bus.stk_unf);
        end
    endtask

    task automatic test_call_return();
        drive(1, 0, 2'd2, 0, 0, 'h010, 0);
        drive(1, 1, 2'd2, 1, 0, 'h200, 0);
        checks++;
        if (bus.pc !== 10'h200 || bus.stack_lvl !== 4'd1 || bus.taken !== 1'b1) begin
            errors++;
            $display("FAIL call got pc=%0h lvl=%0d taken=%b exp pc=200 lvl=1 taken=1", bus.pc, bus.stack_lvl, bus.taken);
        end
        drive(1, 1, 2'd3, 0, 1, 0, 0);
        checks++;
        if (bus.pc !== 10'h011 || bus.stack_lvl !== 4'd0 || bus.taken !== 1'b1) begin
            errors++;
            $display("FAIL return got pc=%0h lvl=%0d taken=%b exp pc=11 lvl=0 taken=1", bus.pc, bus.stack_lvl, bus.taken);
        end
    endtask

    task automatic test_overflow();
        int pushed[DEPTH];
        int prev;
        drive(1, 0, 2'd2, 0, 0, 'h050, 0);
        prev = 'h050;
        for (int k = 0; k < DEPTH; k++) begin
            pushed[k] = prev + 1;
            drive(1, 0, 2'd2, 1, 0, 'h100 + k * 16, 0);
            prev = 'h100 + k * 16;
            checks++;
            if (bus.stack_lvl !== 4'(k + 1)) begin errors++; $display("FAIL nest_lvl%0d got=%0d exp=%0d", k, bus.stack_lvl, k + 1); end
        end
        drive(1, 1, 2'd2, 1, 0, 'h300, 0);
        checks++;
        if (bus.stack_full !== 1'b1 || bus.stk_ovf !== 1'b1 || bus.stack_lvl !== 4'd8 || bus.pc !== AW'(OVF_PC)) begin
            errors++;
            $display("FAIL overflow got full=%b ovf=%b lvl=%0d pc=%0h exp full=1 ovf=1 lvl=8 pc=%0h", bus.stack_full, bus.stk_ovf, bus.stack_lvl, bus.pc, OVF_PC);
        end
        drive(1, 0, 2'd0, 1, 0, 0, 1);
        checks++;
        if (bus.stk_ovf !== 1'b1) begin errors++; $display("FAIL clr_vs_new_err got ovf=%b exp=1", bus.stk_ovf); end
        drive(1, 0, 2'd0, 0, 0, 0, 1);
        checks++;
        if (bus.stk_ovf !== 1'b0) begin errors++; $display("FAIL clr_err got ovf=%b exp=0", bus.stk_ovf); end
        for (int k = DEPTH - 1; k >= 0; k--) begin
            drive(1, 0, 2'd3, 0, 1, 0, 0);
            checks++;
            if (bus.pc !== AW'(pushed[k]) || bus.stack_lvl !== 4'(k)) begin
                errors++;
                $display("FAIL unwind%0d got pc=%0h lvl=%0d exp pc=%0h lvl=%0d", k, bus.pc, bus.stack_lvl, pushed[k], k);
            end
        end
    endtask

    task automatic test_underflow_illegal();
        int exp_pc;
        drive(1, 1, 2'd3, 0, 1, 0, 0);
        checks++;
        if (bus.pc !== AW'(UNF_PC) || bus.stk_unf !== 1'b1 || bus.stack_lvl !== 4'd0 || bus.taken !== 1'b1) begin
            errors++;
            $display("FAIL underflow got pc=%0h unf=%b lvl=%0d taken=%b exp pc=%0h unf=1 lvl=0 taken=1", bus.pc, bus.stk_unf, bus.stack_lvl, bus.taken, UNF_PC);
        end
        drive(1, 0, 2'd0, 0, 0, 0, 1);
        drive(1, 0, 2'd1, 1, 0, 0, 0);
        drive(1, 0, 2'd1, 1, 1, 0, 0);
        exp_pc = (UNF_PC + 2) % (1 << AW);
        checks++;
        if (bus.stack_lvl !== 4'd1 || bus.stk_ovf !== 1'b0 || bus.stk_unf !== 1'b0 || bus.pc !== AW'(exp_pc)) begin
            errors++;
            $display("FAIL call_and_return got lvl=%0d flags=%b%b pc=%0h exp lvl=1 flags=00 pc=%0h", bus.stack_lvl, bus.stk_ovf, bus.stk_unf, bus.pc, exp_pc);
        end
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0;
        model_reset();
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) drive(1, 0, 2'd2, 1, 0, 'h155, 0);
        drive(1, 0, 2'd3, 0, 1, 0, 0);
        drive(1, 0, 2'd0, 0, 1, 0, 0);
        drive(1, 0, 2'd0, 0, 1, 0, 0);
        drive(1, 0, 2'd3, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) drive(1, 0, 2'd2, 1, 0, 'h155, 0);
        checks++;
        if (bus.stack_lvl !== 4'd3 || bus.pc !== 10'h155 || bus.stk_unf !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got lvl=%0d pc=%0h unf=%b exp lvl=3 pc=155 unf=1", bus.stack_lvl, bus.pc, bus.stk_unf);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.pc !== AW'(RPC) || bus.stack_lvl !== 4'd0 || bus.stk_ovf !== 1'b0 || bus.stk_unf !== 1'b0 || bus.taken !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got pc=%0h lvl=%0d flags=%b%b taken=%b exp pc=0 lvl=0 flags=00 taken=0", bus.pc, bus.stack_lvl, bus.stk_ovf, bus.stk_unf, bus.taken);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_freeze();
        drive(1, 1, 2'd2, 1, 0, 'h0AA, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 2'(k + 1), 1, k == 2, 'h3FF, 1);
            checks++;
            if (bus.pc !== 10'h0AA || bus.stack_lvl !== 4'd1 || bus.taken !== 1'b1 || bus.stk_ovf !== 1'b0) begin
                errors++;
                $display("FAIL freeze%0d got pc=%0h lvl=%0d taken=%b ovf=%b exp pc=aa lvl=1 taken=1 ovf=0", k, bus.pc, bus.stack_lvl, bus.taken, bus.stk_ovf);
            end
        end
    endtask

    task automatic test_random();
        int nerr;
        rst_n = 1'b0;
        model_reset();
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        nerr = 0;
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 9) != 0, 1'($urandom), 2'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  int'($urandom_range(0, 1023)), $urandom_range(0, 7) == 0);
            checks++;
            if (bus.pc !== AW'(m_pc) || bus.stack_lvl !== 4'(m_stk.size()) ||
                bus.stk_ovf !== m_ovf || bus.stk_unf !== m_unf || bus.taken !== m_taken ||
                bus.stack_full !== (m_stk.size() == DEPTH) || bus.stack_empty !== (m_stk.size() == 0)) begin
                errors++;
                nerr++;
                if (nerr <= 10)
                    $display("FAIL random%0d got pc=%0h lvl=%0d ovf=%b unf=%b taken=%b full=%b empty=%b exp pc=%0h lvl=%0d ovf=%b unf=%b taken=%b",
                             n, bus.pc, bus.stack_lvl, bus.stk_ovf, bus.stk_unf, bus.taken, bus.stack_full, bus.stack_empty,
                             m_pc, m_stk.size(), m_ovf, m_unf, m_taken);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.en = 0; bus.jump = 0; bus.j_mode = 2'd0; bus.call = 0;
        bus.ret = 0; bus.target = '0; bus.clr_err = 0;
        test_reset();
        test_increment_wrap();
        test_call_return();
        test_overflow();
        test_underflow_illegal();
        test_async_reset();
        test_freeze();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
